sw_max_score_ctrl: RTL and testbench
====================================

# sw_max_score_ctrl

Sequences the pipelined 64-lane max-reduction tree that follows the PE array, turning a stream of per-column PE score vectors into one best local-alignment score per query/target run. It masks unused PE lanes, tags each beat as it passes through the external tree, accumulates the running maximum and its column index, and reports the result to the top-level controller with a done/ack handshake.

## Interface
- DATA_WIDTH, 18: score width; MSB is the sign, the lower bits are magnitude.
- LANES, 64: number of PE lanes feeding the tree.
- TREE_LAT, 2: registered latency of the external tree, in clock edges.
- COL_BITS, 13: width of the column counter; sized for a maximum target length of 1024 × 7.
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- i_start  in  1  begin a new run; accepted only in IDLE.
- i_lane_cnt  in  7  number of active lanes (1..64), latched on an accepted i_start.
- i_valid  in  1  PE score vector valid this cycle.
- i_last  in  1  qualifies i_valid; marks the final beat of the run.
- i_data  in  DATA_WIDTH*LANES  PE V scores; lane k occupies bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
- o_tree_in  out  DATA_WIDTH*LANES  masked scores driven to the tree (combinational).
- i_tree_result  in  DATA_WIDTH  tree output.
- o_ready  out  1  high in IDLE.
- o_done  out  1  result valid; held until acknowledged.
- i_ack  in  1  consumes the result.
- o_score  out  DATA_WIDTH  best score; always ≥ 0.
- o_col  out  COL_BITS  0-based beat index where o_score was first reached.
- o_col_ovf  out  1  sticky flag: the column counter saturated during this run.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE. The state register is 2 bits.
- **IDLE:** o_ready=1.
  - i_start → RUN.
  - On that same edge: clear best, best_col, col_cnt and o_col_ovf; latch i_lane_cnt. A latched value of 0 is treated as 64.
  - i_valid is ignored in IDLE.
- **Lane masking:** lanes ≥ lane_cnt drive 0 on o_tree_in. Active lanes pass i_data unchanged. Masking applies in every state.
- **RUN:** each i_valid beat pushes a tag {valid, col_cnt, last} into a TREE_LAT-deep shift register, then col_cnt increments.
  - col_cnt saturates at 2^COL_BITS−1. An attempted increment past saturation sets o_col_ovf.
  - i_valid & i_last → DRAIN.
  - i_start is ignored while not in IDLE.
- **DRAIN:** i_valid is ignored; no tags are pushed. Bubbles (invalid tags) flow through the shift register normally.
- **Accumulate** (RUN and DRAIN): when the output tag is valid, compute r = i_tree_result.
  - If the r sign bit is set, r is treated as 0.
  - If r > best (strictly greater), then best ← r and best_col ← tag.col. Ties keep the earlier column.
- **Completion:** when the output tag has last=1, the same edge performs the accumulate step and transitions to DONE.
- **DONE:** o_done=1. o_score and o_col hold the final best and best_col.
  - i_ack → IDLE.
  - i_ack in any other state is ignored.
- **Reset** (asynchronous, any state, including mid-run):
  - state=IDLE, tag pipe cleared, best=0, best_col=0, col_cnt=0, lane_cnt=64.
  - Outputs: o_done=0, o_score=0, o_col=0, o_col_ovf=0, o_ready=1.

## Timing
- A beat sampled at edge E0 has its result on i_tree_result after edge E(TREE_LAT−1). It is accumulated at edge E(TREE_LAT).
- For the last beat at E0:
  - state is DRAIN from E0;
  - state becomes DONE at E(TREE_LAT);
  - o_done is first high in the cycle after E2 (default latency).
- Back-to-back beats are accepted every cycle with no stall; the block has no backpressure on i_valid.
- DONE → IDLE on the edge where i_ack=1. i_start can be accepted on the following edge at the earliest.
- A run with i_valid & i_last on the first RUN cycle is legal: single beat, o_col=0.
- i_start and i_ack arriving together in DONE: only i_ack acts.

## Test plan
- **Reset values:** assert rst_n=0 mid-RUN with beats in flight → next cycle state=IDLE, o_ready=1, o_done=0, o_score=0, o_col=0, o_col_ovf=0; a tree result arriving after reset changes nothing.
- **Basic run:** lane_cnt=64, three beats whose maxima are 5, 40, 12 (tree model with TREE_LAT=2), last on beat 2 → o_done 3 cycles after beat 2, o_score=40, o_col=1; hold until i_ack.
- **Masking and tie:** lane_cnt=3, lane 10 carries 500, lanes 0–2 max is 7 on beats 0 and 2 → o_tree_in lanes 3..63 are 0, o_score=7, o_col=0.
- **Negative and bubbles:** all lanes negative (sign set), with idle cycles interleaved between beats → o_score=0, o_col=0, no extra columns counted.
- **Protocol:** i_start pulsed during RUN/DRAIN/DONE is ignored; i_ack in RUN is ignored; single-beat run gives o_col=0; i_start on the cycle after ack is accepted.
- **Saturation:** COL_BITS=3, 10 beats with increasing max → o_col=7, o_col_ovf=1; cleared on the next i_start.

Source files
------------

// File: rtl/sw_max_score_ctrl_if.sv
// Bus bundle between the top-level controller/PE array and the max-score
// sequencer. The controller side uses the master modport, the sequencer the
// slave modport.
//
// Handshakes: i_start is a single-cycle request taken only while o_ready is
// high (IDLE); i_valid/i_last are taken every cycle with no backpressure;
// o_done stays high with o_score/o_col/o_col_ovf stable until the cycle
// i_ack is sampled high.
interface sw_max_score_ctrl_if #(
   parameter int DATA_WIDTH = 18,
   parameter int LANES      = 64,
   parameter int COL_BITS   = 13
);
   // run control
   logic                        i_start;
   logic [6:0]                  i_lane_cnt;
   logic                        o_ready;
   // score stream from the PE array
   logic                        i_valid;
   logic                        i_last;
   logic [DATA_WIDTH*LANES-1:0] i_data;
   // external reduction tree
   logic [DATA_WIDTH*LANES-1:0] o_tree_in;
   logic [DATA_WIDTH-1:0]       i_tree_result;
   // result handshake
   logic                        o_done;
   logic                        i_ack;
   logic [DATA_WIDTH-1:0]       o_score;
   logic [COL_BITS-1:0]         o_col;
   logic                        o_col_ovf;
   // FSM state for observation: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
   logic [1:0]                  dbg_state;

   modport master (
      output i_start, i_lane_cnt, i_valid, i_last, i_data, i_tree_result, i_ack,
      input  o_ready, o_tree_in, o_done, o_score, o_col, o_col_ovf, dbg_state
   );

   modport slave (
      input  i_start, i_lane_cnt, i_valid, i_last, i_data, i_tree_result, i_ack,
      output o_ready, o_tree_in, o_done, o_score, o_col, o_col_ovf, dbg_state
   );
endinterface

// File: rtl/sw_max_score_ctrl.sv
// Sequencer around the pipelined max-reduction tree that follows the PE
// array. Masks unused lanes, tags each beat as it travels through the tree,
// keeps the running best score with its first column, and hands the result
// to the controller with a done/ack handshake.
module sw_max_score_ctrl #(
   parameter int DATA_WIDTH = 18,
   parameter int LANES      = 64,
   parameter int TREE_LAT   = 2,
   parameter int COL_BITS   = 13
) (
   input logic                clk,
   input logic                rst_n,
   sw_max_score_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [COL_BITS-1:0] COL_MAX   = '1;
   localparam logic [6:0]          LANES_ALL = 7'd64;

   state_t                  state;
   state_t                  state_nxt;

   logic [6:0]              lane_cnt;
   logic [LANES-1:0]        lane_act;

   // tag pipe: one entry per tree register stage, index TREE_LAT-1 lines up
   // with the value currently presented on i_tree_result
   logic [TREE_LAT-1:0]     tag_valid;
   logic [TREE_LAT-1:0]     tag_last;
   logic [COL_BITS-1:0]     tag_col [TREE_LAT];

   logic [COL_BITS-1:0]     col_cnt;
   logic [COL_BITS-1:0]     best_col;
   logic [DATA_WIDTH-1:0]   best;
   logic                    col_ovf;

   logic                    start_ok;
   logic                    push;
   logic                    acc_en;
   logic                    acc_win;
   logic                    out_last;
   logic [DATA_WIDTH-1:0]   r_clip;

   // accepted events and the accumulate decision
   assign start_ok = (state == S_IDLE) && bus.i_start;
   assign push     = (state == S_RUN) && bus.i_valid;
   assign acc_en   = ((state == S_RUN) || (state == S_DRAIN)) && tag_valid[TREE_LAT-1];
   assign out_last = acc_en && tag_last[TREE_LAT-1];
   // negative tree results count as zero so the best score never goes below 0
   assign r_clip   = bus.i_tree_result[DATA_WIDTH-1] ? '0 : bus.i_tree_result;
   assign acc_win  = acc_en && (r_clip > best);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.i_start) state_nxt = S_RUN;
         S_RUN:   if (bus.i_valid && bus.i_last) state_nxt = S_DRAIN;
         S_DRAIN: if (out_last) state_nxt = S_DONE;
         S_DONE:  if (bus.i_ack) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      bus.o_ready   = (state == S_IDLE);
      bus.o_done    = (state == S_DONE);
      bus.dbg_state = state;
   end

   // lane enables from the latched active-lane count
   always_comb begin
      lane_act = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_act[k] = (32'(k) < 32'(lane_cnt));
      end
   end

   // inactive lanes feed zeros to the tree so they can never win the max
   for (genvar g = 0; g < LANES; g++) begin : g_mask
      assign bus.o_tree_in[g*DATA_WIDTH +: DATA_WIDTH] =
         lane_act[g] ? bus.i_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;
   end

   // tag pipe shifts every cycle; idle cycles insert bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid <= '0;
         tag_last  <= '0;
         for (int i = 0; i < TREE_LAT; i++) begin
            tag_col[i] <= '0;
         end
      end else begin
         for (int i = TREE_LAT - 1; i > 0; i--) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_last[i]  <= tag_last[i-1];
            tag_col[i]   <= tag_col[i-1];
         end
         tag_valid[0] <= push;
         tag_last[0]  <= push && bus.i_last;
         tag_col[0]   <= col_cnt;
      end
   end

   // run context, column counter with saturation, and the running maximum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt <= LANES_ALL;
         col_cnt  <= '0;
         col_ovf  <= 1'b0;
         best     <= '0;
         best_col <= '0;
      end else if (start_ok) begin
         lane_cnt <= (bus.i_lane_cnt == 7'd0) ? LANES_ALL : bus.i_lane_cnt;
         col_cnt  <= '0;
         col_ovf  <= 1'b0;
         best     <= '0;
         best_col <= '0;
      end else begin
         if (push) begin
            if (col_cnt == COL_MAX) begin
               col_ovf <= 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
         end
         // strict compare keeps the earliest column on ties
         if (acc_win) begin
            best     <= r_clip;
            best_col <= tag_col[TREE_LAT-1];
         end
      end
   end

   assign bus.o_score   = best;
   assign bus.o_col     = best_col;
   assign bus.o_col_ovf = col_ovf;

endmodule

// File: tb/tb_sw_max_score_ctrl.sv
// Directed bench for sw_max_score_ctrl. A second instance with a 3-bit
// column counter shares all stimulus and is only checked for saturation.
module tb_sw_max_score_ctrl;

   localparam int DW = 18;
   localparam int L  = 64;
   localparam int W  = DW * L;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   sw_max_score_ctrl_if #(.DATA_WIDTH(DW), .LANES(L), .COL_BITS(13)) bus ();
   sw_max_score_ctrl_if #(.DATA_WIDTH(DW), .LANES(L), .COL_BITS(3))  bus3 ();

   sw_max_score_ctrl #(.DATA_WIDTH(DW), .LANES(L), .TREE_LAT(2), .COL_BITS(13)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   sw_max_score_ctrl #(.DATA_WIDTH(DW), .LANES(L), .TREE_LAT(2), .COL_BITS(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   // clock
   always #5 clk = ~clk;

   // reference tree: signed max over all lanes, two register stages
   function automatic logic [DW-1:0] tree_max(input logic [W-1:0] v);
      logic signed [DW-1:0] m;
      logic signed [DW-1:0] x;
      m = v[DW-1:0];
      for (int k = 1; k < L; k++) begin
         x = v[k*DW +: DW];
         if (x > m) m = x;
      end
      return m;
   endfunction

   logic [DW-1:0] t1 = '0;
   logic [DW-1:0] t2 = '0;
   always @(posedge clk) begin
      t1 <= tree_max(bus.o_tree_in);
      t2 <= t1;
   end
   assign bus.i_tree_result  = t2;
   assign bus3.i_tree_result = t2;

   // second instance mirrors the stimulus of the first
   assign bus3.i_start    = bus.i_start;
   assign bus3.i_lane_cnt = bus.i_lane_cnt;
   assign bus3.i_valid    = bus.i_valid;
   assign bus3.i_last     = bus.i_last;
   assign bus3.i_data     = bus.i_data;
   assign bus3.i_ack      = bus.i_ack;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] fill(input logic [DW-1:0] v);
      logic [W-1:0] r;
      for (int k = 0; k < L; k++) r[k*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [W-1:0] one_lane(input int lane, input logic [DW-1:0] v);
      logic [W-1:0] r;
      r = '0;
      r[lane*DW +: DW] = v;
      return r;
   endfunction

   task automatic start_run(input logic [6:0] n);
      bus.i_start    = 1'b1;
      bus.i_lane_cnt = n;
      step();
      bus.i_start = 1'b0;
   endtask

   task automatic beat(input logic [W-1:0] v, input logic last);
      bus.i_valid = 1'b1;
      bus.i_last  = last;
      bus.i_data  = v;
      step();
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 16 && !bus.o_done; i++) step();
      check(tag, bus.o_done, 1'b1);
   endtask

   task automatic ack();
      bus.i_ack = 1'b1;
      step();
      bus.i_ack = 1'b0;
   endtask

   logic [W-1:0] v;

   initial begin
      bus.i_start    = 1'b0;
      bus.i_lane_cnt = 7'd0;
      bus.i_valid    = 1'b0;
      bus.i_last     = 1'b0;
      bus.i_data     = '0;
      bus.i_ack      = 1'b0;

      // reset values
      #1 rst_n = 1'b0;
      #2;
      check("rst_state", bus.dbg_state, ST_IDLE);
      check("rst_ready", bus.o_ready, 1'b1);
      check("rst_done",  bus.o_done, 1'b0);
      check("rst_score", bus.o_score, 0);
      check("rst_col",   bus.o_col, 0);
      check("rst_ovf",   bus.o_col_ovf, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // basic run: maxima 5, 40, 12
      start_run(7'd64);
      check("basic_run_state", bus.dbg_state, ST_RUN);
      check("basic_run_ready", bus.o_ready, 1'b0);
      v = fill(18'd1); v[17*DW +: DW] = 18'd5;  beat(v, 1'b0);
      v = fill(18'd1); v[63*DW +: DW] = 18'd40; beat(v, 1'b0);
      v = fill(18'd1); v[0 +: DW]     = 18'd12; beat(v, 1'b1);
      check("basic_drain", bus.dbg_state, ST_DRAIN);
      check("basic_done_l0", bus.o_done, 1'b0);
      step();
      check("basic_done_l1", bus.o_done, 1'b0);
      step();
      check("basic_done_l2", bus.o_done, 1'b1);
      check("basic_score", bus.o_score, 40);
      check("basic_col", bus.o_col, 1);
      repeat (3) step();
      check("basic_hold_done", bus.o_done, 1'b1);
      check("basic_hold_score", bus.o_score, 40);
      ack();
      check("basic_ack_idle", bus.o_ready, 1'b1);
      check("basic_ack_done", bus.o_done, 1'b0);

      // masking and tie: lane_cnt=3, lane 10 carries 500
      start_run(7'd3);
      v = fill(18'd500); v[0 +: DW] = 18'd7; v[DW +: DW] = 18'd2; v[2*DW +: DW] = 18'd3;
      bus.i_valid = 1'b1; bus.i_last = 1'b0; bus.i_data = v;
      #1;
      check("mask_hi_zero", (bus.o_tree_in[W-1:3*DW] != '0), 1'b0);
      check("mask_l0", bus.o_tree_in[0 +: DW], 7);
      check("mask_l2", bus.o_tree_in[2*DW +: DW], 3);
      step();
      bus.i_valid = 1'b0;
      v = fill(18'd500); v[0 +: DW] = 18'd1; v[DW +: DW] = 18'd6; v[2*DW +: DW] = 18'd4;
      beat(v, 1'b0);
      v = fill(18'd500); v[0 +: DW] = 18'd3; v[DW +: DW] = 18'd4; v[2*DW +: DW] = 18'd7;
      beat(v, 1'b1);
      wait_done("mask_done");
      check("mask_score", bus.o_score, 7);
      check("mask_col", bus.o_col, 0);
      ack();

      // all-negative beats with bubbles
      start_run(7'd0);
      v = fill(18'h3FFFF); v[3*DW +: DW] = 18'h3FFFB; beat(v, 1'b0);
      step(); step();
      beat(fill(18'h20005), 1'b0);
      step();
      beat(fill(18'h3FFFF), 1'b1);
      wait_done("neg_done");
      check("neg_score", bus.o_score, 0);
      check("neg_col", bus.o_col, 0);
      ack();

      // bubbles are not counted as columns
      start_run(7'd64);
      beat(fill(18'h3FFF0), 1'b0);
      step(); step();
      beat(fill(18'h20001), 1'b0);
      step();
      beat(one_lane(2, 18'd9), 1'b1);
      wait_done("bub_done");
      check("bub_score", bus.o_score, 9);
      check("bub_col", bus.o_col, 2);
      ack();

      // protocol: start in RUN/DRAIN/DONE and ack in RUN are ignored
      start_run(7'd64);
      bus.i_start = 1'b1; bus.i_lane_cnt = 7'd1;
      beat(one_lane(40, 18'd3), 1'b0);
      bus.i_start = 1'b0;
      check("proto_run_start", bus.dbg_state, ST_RUN);
      bus.i_ack = 1'b1;
      beat(one_lane(40, 18'd2), 1'b0);
      bus.i_ack = 1'b0;
      check("proto_run_ack", bus.dbg_state, ST_RUN);
      beat(one_lane(40, 18'd1), 1'b1);
      bus.i_start = 1'b1;
      step();
      check("proto_drain_start", bus.dbg_state, ST_DRAIN);
      step();
      check("proto_done", bus.dbg_state, ST_DONE);
      step();
      check("proto_done_start", bus.dbg_state, ST_DONE);
      check("proto_score", bus.o_score, 3);
      check("proto_col", bus.o_col, 0);
      bus.i_ack = 1'b1;
      step();
      bus.i_ack = 1'b0; bus.i_start = 1'b0;
      check("proto_start_ack", bus.dbg_state, ST_IDLE);

      // start right after ack, single-beat run
      start_run(7'd64);
      check("single_start", bus.dbg_state, ST_RUN);
      beat(one_lane(7, 18'd11), 1'b1);
      wait_done("single_done");
      check("single_score", bus.o_score, 11);
      check("single_col", bus.o_col, 0);
      ack();

      // saturation: ten beats with maxima 1..10
      start_run(7'd64);
      for (int b = 0; b < 10; b++) beat(one_lane(5, 18'(b + 1)), b == 9);
      wait_done("sat_done");
      check("sat_score", bus.o_score, 10);
      check("sat_col", bus.o_col, 9);
      check("sat_ovf", bus.o_col_ovf, 1'b0);
      check("sat3_score", bus3.o_score, 10);
      check("sat3_col", bus3.o_col, 7);
      check("sat3_ovf", bus3.o_col_ovf, 1'b1);
      ack();
      check("sat3_ovf_idle", bus3.o_col_ovf, 1'b1);
      start_run(7'd64);
      check("sat3_ovf_clr", bus3.o_col_ovf, 1'b0);

      // reset mid-run with beats in flight
      beat(one_lane(9, 18'd30), 1'b0);
      beat(one_lane(9, 18'd50), 1'b0);
      #2 rst_n = 1'b0;
      step();
      check("mrst_state", bus.dbg_state, ST_IDLE);
      check("mrst_ready", bus.o_ready, 1'b1);
      check("mrst_done", bus.o_done, 1'b0);
      check("mrst_score", bus.o_score, 0);
      check("mrst_col", bus.o_col, 0);
      check("mrst_ovf", bus.o_col_ovf, 1'b0);
      rst_n = 1'b1;
      repeat (3) step();
      check("mrst_tree_nz", bus.i_tree_result, 50);
      check("mrst_after_score", bus.o_score, 0);
      check("mrst_after_state", bus.dbg_state, ST_IDLE);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
